// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush and an optional load-use bubble inserter.
// Optional feature macro: ID_EX_HAZARD_EN (load-use detection, hazard_stall, bubble_cnt).
module id_ex_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CTRL_W     = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    input  logic [REG_ADDR_W-1:0] in_rs,
    input  logic [REG_ADDR_W-1:0] in_rt,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic                  in_mem_read,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_pc,
    output logic [DATA_W-1:0]     out_a,
    output logic [DATA_W-1:0]     out_b,
    output logic [DATA_W-1:0]     out_imm,
    output logic [REG_ADDR_W-1:0] out_rs,
    output logic [REG_ADDR_W-1:0] out_rt,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic                  out_mem_read,
    output logic                  hazard_stall,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic load_use;

`ifdef ID_EX_HAZARD_EN
    // r0 is hardwired zero, so a load targeting it can never feed a consumer.
    always_comb begin
        load_use = out_valid & out_mem_read & (out_rd != '0) & in_valid
                   & ((out_rd == in_rs) | (out_rd == in_rt));
        hazard_stall = load_use & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (!flush && !stall && load_use && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        load_use     = 1'b0;
        hazard_stall = 1'b0;
        bubble_cnt   = '0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_a        <= '0;
            out_b        <= '0;
            out_imm      <= '0;
            out_rs       <= '0;
            out_rt       <= '0;
            out_rd       <= '0;
            out_ctrl     <= '0;
            out_mem_read <= 1'b0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_a        <= '0;
            out_b        <= '0;
            out_imm      <= '0;
            out_rs       <= '0;
            out_rt       <= '0;
            out_rd       <= '0;
            out_ctrl     <= '0;
            out_mem_read <= 1'b0;
        end else if (stall) begin
            out_valid    <= out_valid;
        end else if (load_use) begin
            // Bubble: kill the slot but keep the data fields as they were.
            out_valid    <= 1'b0;
            out_ctrl     <= '0;
            out_mem_read <= 1'b0;
        end else begin
            out_valid    <= in_valid;
            out_pc       <= in_pc;
            out_a        <= in_a;
            out_b        <= in_b;
            out_imm      <= in_imm;
            out_rs       <= in_rs;
            out_rt       <= in_rt;
            out_rd       <= in_rd;
            out_ctrl     <= in_valid ? in_ctrl : '0;
            out_mem_read <= in_valid & in_mem_read;
        end
    end

endmodule
